dsp_mac_sequencer: RTL and testbench
====================================

// Module: dsp_mac_sequencer
// PURPOSE
//  Upstream control stage for one DSP48A1 slice. Accepts a stream of (a,b) operand beats
//  and drives the slice's A/B/OPMODE/CEP inputs to form an N-tap dot product.
//  Captures the final P into a result buffer with valid/ready output.
//  Slice integration is fixed:
//  - default pipeline: A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, B_INPUT="DIRECT"
//  - CEA/CEB/CEM/CEOPMODE tied 1, CARRYIN tied 0
// PARAMETERS
//  TAPS_W   8   width of the tap-count input and internal tap counter
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  in_valid    in   1   operand beat valid
//  in_ready    out  1   sequencer can accept a beat
//  in_a        in   18  multiplicand beat
//  in_b        in   18  multiplier beat
//  in_taps     in   TAPS_W  taps in this dot product; sampled on the first beat only
//  dsp_a       out  18  to slice A
//  dsp_b       out  18  to slice B
//  dsp_opmode  out  8   to slice OPMODE
//  dsp_cep     out  1   to slice CEP
//  dsp_p       in   48  from slice P
//  out_valid   out  1   result available
//  out_ready   in   1   downstream takes result
//  out_data    out  48  dot-product result (raw P)
//  out_taps    out  TAPS_W  tap count that produced out_data
// BEHAVIOUR
//  Reset values (async, all zero): state=IDLE, counters=0, dsp_a, dsp_b, dsp_opmode,
//   dsp_cep, out_valid, out_data, out_taps; in_ready=1 after reset.
//  Beat accepted at edge e when in_valid&in_ready. Slice-side timing (registered outputs):
//   - dsp_a/dsp_b take in_a/in_b at edge e; they hold between beats.
//   - dsp_opmode updates at edge e+1:
//       8'h01 (X=M, Z=0) if the beat was the first tap
//       8'h09 (X=M, Z=P) otherwise
//       8'h00 at every edge with no beat one cycle earlier
//   - dsp_cep is high exactly during cycle e+2 (one-cycle pulse per beat).
//   Pre-adder, carry and subtract are never used: OPMODE[7:4]=0 always.
//  Input bubbles (in_valid low mid-product) are legal. Gated CEP keeps P unchanged.
//  FSM:
//   IDLE:  in_ready=1.
//     - On accept, latch taps = (in_taps==0 ? 1 : in_taps) and remaining=taps-1.
//     - Go to FLUSH if remaining==0, else ACCUM.
//   ACCUM: in_ready=1. Each accept decrements remaining. Accepting the last tap -> FLUSH.
//   FLUSH: in_ready=0. Wait 4 clocks after the last accept edge L.
//     - Final P is visible after edge L+3.
//     - At edge L+4: out_data<=dsp_p, out_taps<=latched taps, out_valid<=1 -> HOLD.
//   HOLD:  in_ready=0, out_valid=1, out_data/out_taps stable.
//     - out_ready high -> out_valid<=0 at that edge -> IDLE.
//     - The next product may start the cycle after.
//  in_ready is a registered function of state; no combinational path from out_ready.
//  Arithmetic: signed 18x18 products in the slice; out_data is the raw 48-bit P with no
//   saturation. Wrap-around follows the slice.
//  in_taps changes after the first beat are ignored. out_taps wraps naturally for TAPS_W.
//  rst mid-product: immediate return to IDLE and all outputs zero.
//   - Partial product is discarded; no out_valid is produced for it.
//   - Slice P is not cleared; the next product's first tap (Z=0) makes it irrelevant.
// TESTING (bench instantiates DSP48A1 with default params, wired as above)
//  1. in_taps=1, a=3, b=5 -> out_valid 4 clocks after accept edge,
//     out_data=48'd15, out_taps=1.
//  2. in_taps=4, a={1,2,3,4}, b={10,20,30,40} back-to-back -> out_data=300.
//     dsp_opmode sequence 01,09,09,09.
//  3. Same as 2 with 2-cycle bubbles between beats -> out_data=300;
//     dsp_cep shows exactly 4 one-cycle pulses.
//  4. in_taps=2, a={-2,7}, b={3,-1}: out_ready held low 10 cycles.
//     - out_data = 48'hFFFF_FFFF_FFF3 (-13), stable throughout.
//     - in_ready=0 until the cycle after the out_ready handshake.
//  5. in_taps=0, a=9, b=9 -> treated as 1 tap, out_data=81, out_taps=0 latched as 1.
//  6. Assert rst during ACCUM of a 4-tap product -> outputs zero at once,
//     no out_valid for that product. Following 1-tap 2*2 -> out_data=4.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Control stage in front of one DSP48A1 slice: streams (a,b) beats into the slice,
// sequences OPMODE/CEP per tap and buffers the final P behind a valid/ready handshake.
module dsp_mac_sequencer #(
  parameter int TAPS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [17:0]       in_a,
  input  logic [17:0]       in_b,
  input  logic [TAPS_W-1:0] in_taps,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_cep,
  input  logic [47:0]       dsp_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [47:0]       out_data,
  output logic [TAPS_W-1:0] out_taps
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_accept;
  logic                w_last;
  logic [TAPS_W-1:0]   w_taps_eff;
  logic [TAPS_W-1:0]   r_taps;
  logic [TAPS_W-1:0]   r_remaining;
  logic [1:0]          r_flush_cnt;
  logic                r_in_ready;
  logic signed [17:0]  r_a_p0;
  logic signed [17:0]  r_b_p0;
  logic                r_vld_p0;
  logic                r_first_p0;
  logic                r_vld_p1;
  logic [7:0]          r_opmode_p1;
  logic                r_cep_p2;
  logic                r_out_valid;
  logic [47:0]         r_out_data;
  logic [TAPS_W-1:0]   r_out_taps;

  // X=M always; Z=0 restarts the accumulation, Z=P continues it.
  function automatic logic [7:0] opmode_sel(input logic vld, input logic first);
    if (!vld)
      return 8'h00;
    else if (first)
      return 8'h01;
    else
      return 8'h09;
  endfunction

  assign w_accept   = in_valid & r_in_ready;
  assign w_taps_eff = (in_taps == '0) ? TAPS_W'(1) : in_taps;
  assign w_last     = (r_state == IDLE) ? (w_taps_eff == TAPS_W'(1))
                                        : (r_remaining == TAPS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next_state = w_last ? FLUSH : ACCUM;
      ACCUM: if (w_accept && w_last) w_next_state = FLUSH;
      FLUSH: if (r_flush_cnt == 2'd3) w_next_state = HOLD;
      HOLD:  if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_taps      <= '0;
      r_remaining <= '0;
      r_flush_cnt <= '0;
      r_a_p0      <= '0;
      r_b_p0      <= '0;
      r_vld_p0    <= 1'b0;
      r_first_p0  <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_opmode_p1 <= '0;
      r_cep_p2    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_taps  <= '0;
    end else begin
      r_in_ready <= (w_next_state == IDLE) || (w_next_state == ACCUM);
      // p0: operand capture at the accept edge
      if (w_accept) begin
        r_a_p0 <= in_a;
        r_b_p0 <= in_b;
        if (r_state == IDLE) begin
          r_taps      <= w_taps_eff;
          r_remaining <= w_taps_eff - TAPS_W'(1);
        end else begin
          r_remaining <= r_remaining - TAPS_W'(1);
        end
      end
      r_vld_p0   <= w_accept;
      r_first_p0 <= w_accept && (r_state == IDLE);
      // p1: OPMODE lines up with the slice's A1/B1 register stage
      r_opmode_p1 <= opmode_sel(r_vld_p0, r_first_p0);
      r_vld_p1    <= r_vld_p0;
      // p2: CEP enables the P register while M holds this beat's product
      r_cep_p2 <= r_vld_p1;
      if (r_state == FLUSH)
        r_flush_cnt <= r_flush_cnt + 2'd1;
      else
        r_flush_cnt <= '0;
      if (r_state == FLUSH && r_flush_cnt == 2'd3) begin
        r_out_data  <= dsp_p;
        r_out_taps  <= r_taps;
        r_out_valid <= 1'b1;
      end else if (r_state == HOLD && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign dsp_a      = r_a_p0;
  assign dsp_b      = r_b_p0;
  assign dsp_opmode = r_opmode_p1;
  assign dsp_cep    = r_cep_p2;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_taps   = r_out_taps;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 (A1/B1/M/P/OPMODE regs) closes the
// loop; a table of dot products is streamed in and results checked through a scoreboard.
module tb_dsp_mac_sequencer;
  localparam int TAPS_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [17:0]       in_a;
  logic [17:0]       in_b;
  logic [TAPS_W-1:0] in_taps;
  logic [17:0]       dsp_a;
  logic [17:0]       dsp_b;
  logic [7:0]        dsp_opmode;
  logic              dsp_cep;
  logic [47:0]       dsp_p;
  logic              out_valid;
  logic              out_ready;
  logic [47:0]       out_data;
  logic [TAPS_W-1:0] out_taps;

  dsp_mac_sequencer #(.TAPS_W(TAPS_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_taps(in_taps),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_cep(dsp_cep), .dsp_p(dsp_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_taps(out_taps)
  );

  always #5 clk = ~clk;

  // Slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, CEA/CEB/CEM/CEOPMODE=1, CARRYIN=0
  logic signed [17:0] s_a1 = '0;
  logic signed [17:0] s_b1 = '0;
  logic signed [35:0] s_m  = '0;
  logic [7:0]         s_op = '0;
  logic [47:0]        s_p  = '0;
  logic [47:0]        s_x;
  logic [47:0]        s_z;
  always_comb begin
    s_x = (s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
    s_z = (s_op[3:2] == 2'b10) ? s_p : 48'd0;
  end
  always @(posedge clk) begin
    s_a1 <= dsp_a;
    s_b1 <= dsp_b;
    s_m  <= s_a1 * s_b1;
    s_op <= dsp_opmode;
    if (dsp_cep) s_p <= s_x + s_z;
  end
  assign dsp_p = s_p;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] op_log[$];
  int   cep_hi = 0;
  int   cep_rise = 0;
  logic cep_prev = 1'b0;
  logic bad_op = 1'b0;
  always @(negedge clk) begin
    if (dsp_opmode != 8'h00) op_log.push_back(dsp_opmode);
    if (dsp_opmode[7:4] != 4'h0) bad_op <= 1'b1;
    if (dsp_cep) cep_hi <= cep_hi + 1;
    if (dsp_cep && !cep_prev) cep_rise <= cep_rise + 1;
    cep_prev <= dsp_cep;
  end

  typedef struct packed {
    logic [7:0]       taps_in;
    int               n;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    int               gap;
    logic [47:0]      exp_data;
    logic [7:0]       exp_taps;
    int               hold;
  } vec_t;

  typedef struct packed {
    logic [47:0] data;
    logic [7:0]  taps;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int taps, int n, int a0, int a1, int a2, int a3,
                              int b0, int b1, int b2, int b3, int gap,
                              logic [47:0] ed, int et, int hold);
    vec_t v;
    v.taps_in = 8'(taps);
    v.n = n;
    v.a[0] = 18'(a0); v.a[1] = 18'(a1); v.a[2] = 18'(a2); v.a[3] = 18'(a3);
    v.b[0] = 18'(b0); v.b[1] = 18'(b1); v.b[2] = 18'(b2); v.b[3] = 18'(b3);
    v.gap = gap;
    v.exp_data = ed;
    v.exp_taps = 8'(et);
    v.hold = hold;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v, output int last_cyc);
    int guard;
    last_cyc = cyc;
    for (int k = 0; k < v.n; k++) begin
      in_valid = 1'b1;
      in_a     = v.a[k];
      in_b     = v.b[k];
      in_taps  = (k == 0) ? v.taps_in : 8'hFF;
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) check("accept_timeout", 64'(guard), 64'd0);
      @(posedge clk); #1;
      last_cyc = cyc;
      in_valid = 1'b0;
      for (int g = 0; g < v.gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   lc;
    int   guard;
    int   start_op;
    int   start_hi;
    int   start_rise;
    logic stable;
    exp_t e;
    start_op   = op_log.size();
    start_hi   = cep_hi;
    start_rise = cep_rise;
    sb.push_back({v.exp_data, v.exp_taps});
    send(v, lc);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("latency", 64'(cyc - lc), 64'd4);
    check("in_ready_in_hold", 64'(in_ready), 64'd0);
    e = sb.pop_front();
    check("out_data", 64'(out_data), 64'(e.data));
    check("out_taps", 64'(out_taps), 64'(e.taps));
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      if (out_data !== e.data || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_clear", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("opmode_count", 64'(op_log.size() - start_op), 64'(v.n));
    for (int k = 0; k < v.n; k++)
      check("opmode_seq",
            64'((start_op + k < op_log.size()) ? op_log[start_op + k] : 8'hEE),
            64'((k == 0) ? 8'h01 : 8'h09));
    check("cep_cycles", 64'(cep_hi - start_hi), 64'(v.n));
    if (v.gap > 0) check("cep_pulses", 64'(cep_rise - start_rise), 64'(v.n));
  endtask

  initial begin
    int   lc;
    int   seen;
    vec_t rv;
    vecs[0] = mk(1, 1, 3, 0, 0, 0, 5, 0, 0, 0, 0, 48'd15, 1, 0);
    vecs[1] = mk(4, 4, 1, 2, 3, 4, 10, 20, 30, 40, 0, 48'd300, 4, 0);
    vecs[2] = mk(4, 4, 1, 2, 3, 4, 10, 20, 30, 40, 2, 48'd300, 4, 0);
    vecs[3] = mk(2, 2, -2, 7, 0, 0, 3, -1, 0, 0, 0, 48'hFFFF_FFFF_FFF3, 2, 10);
    vecs[4] = mk(0, 1, 9, 0, 0, 0, 9, 0, 0, 0, 0, 48'd81, 1, 0);
    vecs[5] = mk(3, 3, -131072, -131072, -131072, 0, -131072, -131072, -131072, 0, 1,
                 48'h000C_0000_0000, 3, 2);

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_taps = '0; out_ready = 1'b0;
    #12;
    check("rst_dsp_a", 64'(dsp_a), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'd0);
    check("rst_cep", 64'(dsp_cep), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_taps", 64'(out_taps), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a 4-tap product
    rv = mk(4, 2, 5, 6, 0, 0, 7, 8, 0, 0, 0, 48'd0, 4, 0);
    send(rv, lc);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_dsp_a", 64'(dsp_a), 64'd0);
    check("midrst_dsp_b", 64'(dsp_b), 64'd0);
    check("midrst_opmode", 64'(dsp_opmode), 64'd0);
    check("midrst_cep", 64'(dsp_cep), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    run_vec(mk(1, 1, 2, 0, 0, 0, 2, 0, 0, 0, 0, 48'd4, 1, 0));

    check("opmode_upper_zero", 64'(bad_op), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
